// File: rtl/l2sim_pkg.sv
//==============================================================================
// Module      : l2sim_pkg
// Description : Shared constants, types and helpers for the L2 switch test
//               harness: frame layout, MAC map, scheduler state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package l2sim_pkg;

    localparam int         FRAME_W   = 16;
    localparam int         NUM_PORTS = 4;
    localparam int         PORT_W    = 2;

    localparam logic [3:0] SFD   = 4'b0101;
    localparam logic [3:0] MAC_A = 4'hA;
    localparam logic [3:0] MAC_B = 4'hB;
    localparam logic [3:0] MAC_C = 4'hC;
    localparam logic [3:0] MAC_D = 4'hD;

    // Scheduler state encoding
    typedef logic [1:0] sched_state_t;
    localparam sched_state_t ST_IDLE  = 2'd0;
    localparam sched_state_t ST_CLEAR = 2'd1;
    localparam sched_state_t ST_ISSUE = 2'd2;
    localparam sched_state_t ST_GAP   = 2'd3;

    // Result of a source-MAC lookup
    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
    } port_sel_t;

    // One queued frame together with the EndDevice port that sends it
    typedef struct packed {
        logic [PORT_W-1:0]  port;
        logic [FRAME_W-1:0] frame;
    } fifo_entry_t;

    // Map a source MAC nibble to its EndDevice port; valid=0 for unknown MACs
    function automatic port_sel_t mac_to_port(input logic [3:0] mac);
        port_sel_t sel;
        sel.valid = 1'b1;
        sel.port  = '0;
        case (mac)
            MAC_A:   sel.port = 2'd0;
            MAC_B:   sel.port = 2'd1;
            MAC_C:   sel.port = 2'd2;
            MAC_D:   sel.port = 2'd3;
            default: sel.valid = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_fifo.sv
//==============================================================================
// Module      : frame_fifo
// Description : Circular FIFO with wrapping pointers and a separately held
//               occupancy count so full and empty are never ambiguous.
//               DEPTH must be a power of two so the pointers wrap naturally.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module frame_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             FPGA_CLK,
    input  logic             sys_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int               c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               r_full;
    logic               r_empty;
    logic               w_do_push;
    logic               w_do_pop;

    // A push into a full FIFO is only legal when a pop frees a slot in the same cycle
    assign w_do_pop  = i_pop && !r_empty;
    assign w_do_push = i_push && (!r_full || w_do_pop);

    // Next occupancy from the push/pop combination
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents need no reset since the count gates every read
    always_ff @(posedge FPGA_CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, count and registered full/empty flags
    always_ff @(posedge FPGA_CLK or posedge sys_rst) begin
        if (sys_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_depth);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

`default_nettype wire

// File: rtl/tx_frame_scheduler.sv
//==============================================================================
// Module      : tx_frame_scheduler
// Description : Queues test frames from the user-input logic and issues them
//               one at a time to the EndDevice ports with a fixed gap, so
//               serial transmissions through the L2 switch never overlap.
//               Pulses the switch FIFO clear at the start of every burst.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tx_frame_scheduler #(
    parameter int NUM_PORTS  = 4,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 40
) (
    input  logic                     FPGA_CLK,
    input  logic                     sys_rst,
    input  logic                     add_req,
    input  logic [15:0]              add_frame,
    input  logic                     send_req,
    output logic [15:0]              tx_frame,
    output logic [NUM_PORTS-1:0]     tx_valid,
    output logic                     switch_clear,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     queue_full,
    output logic                     drop_pulse
);

    import l2sim_pkg::*;

    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam int c_gap_w = $clog2(GAP_CYCLES + 1);

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;
    logic [c_gap_w-1:0]   r_gap_cnt;
    logic                 w_pop;
    logic                 w_issue_nxt;
    logic                 w_add_ok;
    port_sel_t            w_src_sel;
    fifo_entry_t          w_push_entry;
    fifo_entry_t          w_head;
    logic [c_cnt_w-1:0]   w_count;
    logic                 w_full;
    logic                 w_empty;
    logic [NUM_PORTS-1:0] w_port_onehot;

    logic [15:0]          r_tx_frame;
    logic [NUM_PORTS-1:0] r_tx_valid;
    logic                 r_switch_clear;
    logic                 r_busy;
    logic                 r_drop_pulse;

    // Source decode; the port index travels with the frame through the queue
    assign w_src_sel          = mac_to_port(add_frame[7:4]);
    assign w_push_entry.port  = w_src_sel.port;
    assign w_push_entry.frame = add_frame;

    // Accept when the source is known and a slot is free (a same-cycle pop frees one)
    assign w_add_ok = add_req && w_src_sel.valid && (!w_full || w_pop);

    frame_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fifo_entry_t)),
        .CNT_W (c_cnt_w)
    ) u_frame_fifo (
        .FPGA_CLK    (FPGA_CLK),
        .sys_rst     (sys_rst),
        .i_push      (w_add_ok),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // One-hot strobe pattern for the head entry's port
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port_onehot
        assign w_port_onehot[p] = (w_head.port == PORT_W'(p));
    end

    // Next-state logic; w_issue_nxt marks the edge that loads the issue outputs,
    // so the ISSUE state is the cycle in which tx_valid is high and the head pops
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_issue_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // An add in the same cycle counts, so a send on an empty queue
                // still starts a burst when that add is accepted
                if (send_req && (!w_empty || w_add_ok)) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_state_nxt = ST_ISSUE;
                w_issue_nxt = 1'b1;
            end
            ST_ISSUE: begin
                w_state_nxt = ST_GAP;
                w_pop       = 1'b1;
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    if (!w_empty) begin
                        w_state_nxt = ST_ISSUE;
                        w_issue_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge FPGA_CLK or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Gap counter: loaded during the issue cycle, counts down through GAP
    always_ff @(posedge FPGA_CLK or posedge sys_rst) begin
        if (sys_rst) begin
            r_gap_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_gap_cnt <= c_gap_w'(GAP_CYCLES - 1);
        end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end

    // Registered outputs; tx_frame holds the last issued frame between issues
    always_ff @(posedge FPGA_CLK or posedge sys_rst) begin
        if (sys_rst) begin
            r_tx_frame     <= '0;
            r_tx_valid     <= '0;
            r_switch_clear <= 1'b0;
            r_busy         <= 1'b0;
            r_drop_pulse   <= 1'b0;
        end else begin
            if (w_issue_nxt) begin
                r_tx_frame <= w_head.frame;
            end
            r_tx_valid     <= w_issue_nxt ? w_port_onehot : '0;
            r_switch_clear <= (r_state == ST_IDLE) && (w_state_nxt == ST_CLEAR);
            r_busy         <= (w_state_nxt != ST_IDLE);
            r_drop_pulse   <= add_req && !w_add_ok;
        end
    end

    assign tx_frame     = r_tx_frame;
    assign tx_valid     = r_tx_valid;
    assign switch_clear = r_switch_clear;
    assign busy         = r_busy;
    assign queue_count  = w_count;
    assign queue_full   = w_full;
    assign drop_pulse   = r_drop_pulse;

endmodule

`default_nettype wire

// File: tb/tb_tx_frame_scheduler.sv
//==============================================================================
// Module      : tb_tx_frame_scheduler
// Description : Directed self-checking bench for tx_frame_scheduler with a
//               frame scoreboard checked on every tx_valid strobe.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tx_frame_scheduler;

    logic        FPGA_CLK;
    logic        sys_rst;
    logic        add_req;
    logic [15:0] add_frame;
    logic        send_req;
    logic [15:0] tx_frame;
    logic [3:0]  tx_valid;
    logic        switch_clear;
    logic        busy;
    logic [2:0]  queue_count;
    logic        queue_full;
    logic        drop_pulse;

    int          n_checks;
    int          n_errors;
    int          cyc;
    logic [15:0] sb [$];
    int          issue_cyc [$];

    tx_frame_scheduler #(
        .NUM_PORTS  (4),
        .DEPTH      (4),
        .GAP_CYCLES (40)
    ) dut (
        .FPGA_CLK     (FPGA_CLK),
        .sys_rst      (sys_rst),
        .add_req      (add_req),
        .add_frame    (add_frame),
        .send_req     (send_req),
        .tx_frame     (tx_frame),
        .tx_valid     (tx_valid),
        .switch_clear (switch_clear),
        .busy         (busy),
        .queue_count  (queue_count),
        .queue_full   (queue_full),
        .drop_pulse   (drop_pulse)
    );

    initial FPGA_CLK = 1'b0;
    always #5 FPGA_CLK = ~FPGA_CLK;

    always @(posedge FPGA_CLK) cyc <= cyc + 1;

    // Expected one-hot port strobe from the frame's source MAC nibble
    function automatic logic [3:0] exp_valid(input logic [15:0] f);
        case (f[7:4])
            4'hA:    return 4'b0001;
            4'hB:    return 4'b0010;
            4'hC:    return 4'b0100;
            4'hD:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge FPGA_CLK);
        #1;
    endtask

    // Idle-state add; expectation of acceptance and resulting count given by caller
    task automatic do_add(input logic [15:0] f, input logic acc, input logic [2:0] exp_cnt);
        add_req   = 1'b1;
        add_frame = f;
        if (acc) sb.push_back(f);
        tick();
        add_req = 1'b0;
        check("add_drop", drop_pulse, !acc);
        check("add_count", queue_count, exp_cnt);
    endtask

    task automatic do_send();
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", busy, 0);
    endtask

    // Scoreboard: every tx_valid strobe must match the oldest outstanding frame
    always @(negedge FPGA_CLK) begin
        logic [15:0] exp_f;
        if (!sys_rst && tx_valid !== 4'b0000) begin
            issue_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_issue", tx_valid, 0);
            end else begin
                exp_f = sb.pop_front();
                check("issue_port", tx_valid, exp_valid(exp_f));
                check("issue_frame", tx_frame, exp_f);
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        sys_rst   = 1'b1;
        add_req   = 1'b0;
        add_frame = '0;
        send_req  = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_frame", tx_frame, 0);
        check("rst_valid", tx_valid, 0);
        check("rst_clear", switch_clear, 0);
        check("rst_busy", busy, 0);
        check("rst_count", queue_count, 0);
        check("rst_full", queue_full, 0);
        check("rst_drop", drop_pulse, 0);
        sys_rst = 1'b0;
        tick();

        // Single frame: clear at k+1, issue at k+2, busy drops after the gap
        do_add(16'h5DA7, 1'b1, 3'd1);
        do_send();
        check("t1_clear", switch_clear, 1);
        check("t1_busy", busy, 1);
        tick();
        check("t1_valid", tx_valid, 4'b0001);
        check("t1_frame", tx_frame, 16'h5DA7);
        tick();
        check("t1_clear_one_cycle", switch_clear, 0);
        check("t1_count_after_pop", queue_count, 0);
        repeat (38) tick();
        check("t1_busy_in_gap", busy, 1);
        repeat (2) tick();
        check("t1_busy_low", busy, 0);
        check("t1_frame_hold", tx_frame, 16'h5DA7);
        check("t1_valid_low", tx_valid, 0);

        // Four-frame burst, issued in order, 41 cycles apart
        do_add(16'h5AB1, 1'b1, 3'd1);
        do_add(16'h5AC2, 1'b1, 3'd2);
        do_add(16'h5AD3, 1'b1, 3'd3);
        do_add(16'h5BA4, 1'b1, 3'd4);
        check("t2_full", queue_full, 1);
        issue_cyc.delete();
        do_send();
        wait_idle(400);
        check("t2_issues", issue_cyc.size(), 4);
        for (int i = 1; i < issue_cyc.size(); i++) begin
            check("t2_spacing", issue_cyc[i] - issue_cyc[i-1], 41);
        end
        check("t2_count_end", queue_count, 0);
        check("t2_full_end", queue_full, 0);

        // Overflow: fifth add dropped for one cycle, only four issued
        do_add(16'h5AB1, 1'b1, 3'd1);
        do_add(16'h5AC2, 1'b1, 3'd2);
        do_add(16'h5AD3, 1'b1, 3'd3);
        do_add(16'h5BA4, 1'b1, 3'd4);
        do_add(16'h5DA7, 1'b0, 3'd4);
        tick();
        check("t3_drop_one_cycle", drop_pulse, 0);
        check("t3_count_held", queue_count, 4);
        issue_cyc.delete();
        do_send();
        wait_idle(400);
        check("t3_issues", issue_cyc.size(), 4);
        check("t3_sb_empty", sb.size(), 0);

        // Unknown source rejected; send on empty queue ignored
        do_add(16'h5A31, 1'b0, 3'd0);
        tick();
        check("t4_drop_low", drop_pulse, 0);
        do_send();
        check("t4_no_clear", switch_clear, 0);
        check("t4_not_busy", busy, 0);
        tick();
        check("t4_still_idle", busy, 0);

        // Add into a full queue during the issue cycle; mid-burst send ignored
        do_add(16'h5AB1, 1'b1, 3'd1);
        do_add(16'h5AC2, 1'b1, 3'd2);
        do_add(16'h5AD3, 1'b1, 3'd3);
        do_add(16'h5BA4, 1'b1, 3'd4);
        issue_cyc.delete();
        do_send();
        check("t5_clear", switch_clear, 1);
        tick();
        check("t5_issue_cycle", tx_valid, 4'b0010);
        add_req   = 1'b1;
        add_frame = 16'h5CB9;
        sb.push_back(16'h5CB9);
        tick();
        add_req = 1'b0;
        check("t5_add_on_pop_drop", drop_pulse, 0);
        check("t5_add_on_pop_count", queue_count, 4);
        check("t5_add_on_pop_full", queue_full, 1);
        repeat (5) tick();
        do_send();
        check("t5_no_second_clear", switch_clear, 0);
        tick();
        check("t5_no_second_clear2", switch_clear, 0);
        wait_idle(400);
        check("t5_issues", issue_cyc.size(), 5);
        check("t5_sb_empty", sb.size(), 0);

        // Reset during GAP with two frames queued
        do_add(16'h5AB1, 1'b1, 3'd1);
        do_add(16'h5AC2, 1'b1, 3'd2);
        do_add(16'h5AD3, 1'b1, 3'd3);
        do_send();
        tick();
        tick();
        tick();
        check("t6_count_in_gap", queue_count, 2);
        sys_rst = 1'b1;
        #1;
        check("t6_rst_frame", tx_frame, 0);
        check("t6_rst_valid", tx_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_count", queue_count, 0);
        check("t6_rst_full", queue_full, 0);
        check("t6_rst_clear", switch_clear, 0);
        sb.delete();
        tick();
        sys_rst = 1'b0;
        issue_cyc.delete();
        do_send();
        check("t6_no_clear", switch_clear, 0);
        check("t6_no_busy", busy, 0);
        repeat (50) tick();
        check("t6_no_issue", issue_cyc.size(), 0);
        check("t6_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
